peripheral_ahb4_arbiter: RTL and testbench
==========================================

Name: peripheral_ahb4_arbiter

Overview:
Round-robin arbiter and AHB4 master sequencer that shares one AHB4 slave (the on-chip SRAM peripheral) among NUM_MASTERS simple request/acknowledge clients. It serialises single transfers into AHB address and data phases, honours slave wait states and returns read data or error per client. It sits between the NoC-side clients and the AHB4 memory slave port.

Parameters:
NUM_MASTERS, 4, number of requesting clients (2..16).
HADDR_SIZE, 8, AHB address width.
HDATA_SIZE, 32, AHB data width.

Ports:
hclk  input  1  clock
hresetn  input  1  reset; synchronous, active-low
req  input  NUM_MASTERS  per-client request, held until ack
req_addr  input  NUM_MASTERS*HADDR_SIZE  client i address at [i*HADDR_SIZE +: HADDR_SIZE]
req_write  input  NUM_MASTERS  1=write, 0=read
req_size  input  NUM_MASTERS*3  client hsize encoding
req_wdata  input  NUM_MASTERS*HDATA_SIZE  client write data
ack  output  NUM_MASTERS  one-cycle completion pulse, one-hot or zero
err  output  1  valid with ack; 1 = slave returned ERROR
rdata  output  HDATA_SIZE  read data, valid with ack on reads
hsel  output  1  slave select
haddr  output  HADDR_SIZE  address phase address
hwdata  output  HDATA_SIZE  data phase write data
hwrite  output  1  transfer direction
hsize  output  3  transfer size
hburst  output  3  constant SINGLE (3'b000)
hprot  output  4  constant 4'b0011 (data, privileged, non-bufferable)
htrans  output  2  IDLE (2'b00) or NONSEQ (2'b10) only
hmastlock  output  1  constant 0
hready  output  1  bus hready to slave = hreadyout (combinational)
hreadyout  input  1  slave ready
hrdata  input  HDATA_SIZE  slave read data
hresp  input  1  slave response (0 OKAY, 1 ERROR)

Behaviour:
- Reset: at posedge hclk with hresetn=0: state IDLE, htrans=IDLE, hsel=0, hwrite=0, haddr=0, hsize=0, hwdata=0, ack=0, err=0, rdata=0, rr pointer=0. Transfer in flight is abandoned without ack; clients must re-request.
- FSM states IDLE, ADDR, DATA.
- IDLE: if any req and hreadyout=1, select winner = first requesting index at or above pointer, wrapping modulo NUM_MASTERS; latch its addr/write/size/wdata; go ADDR. No req or hreadyout=0 -> stay IDLE, htrans=IDLE, hsel=0.
- ADDR (one cycle when hreadyout=1): drive hsel=1, htrans=NONSEQ, haddr/hwrite/hsize from latch. If hreadyout=0, hold all signals and stay. On hreadyout=1 go DATA; pointer <= winner+1 mod NUM_MASTERS.
- DATA: htrans=IDLE, hsel=0; hwdata = latched wdata for whole data phase (any direction). Wait while hreadyout=0. On hreadyout=1: capture hrdata into rdata (reads only; rdata holds on writes), err<=hresp, ack[winner]=1 next cycle, go IDLE.
- ack and err are registered: asserted exactly one cycle, cycle after the completing DATA edge; err=0 when ack=0.
- Minimum latency req rise -> ack: 4 cycles (IDLE latch, ADDR, DATA, ack). Throughput: one transfer per 3 cycles, no pipelined overlap.
- Client may drop req in ack cycle; a req still high in the ack cycle is not re-arbitrated before the IDLE evaluation following ack, so a held req issues a second transfer.
- Request inputs ignored after latching; changes mid-transfer have no effect.
- ERROR response: single-cycle check on the final hreadyout=1 DATA cycle only; no retry; err reported with ack.
- Pointer wrap: winner NUM_MASTERS-1 -> pointer 0.
- Simultaneous requests: only one granted per transfer; losers keep req high, no ack.

Test Plan:
- Single read: req[2]=1, addr 0x10, memory 0x11223344, hreadyout=1 -> haddr=0x10 NONSEQ one cycle, ack=4'b0100 at cycle 4, rdata=0x11223344, err=0.
- Write then read: client 0 writes 0xDEADBEEF size WORD to 0x20, then reads 0x20 -> ack each, rdata=0xDEADBEEF.
- Round robin: req=4'b1111 held, 8 transfers -> ack sequence 0,1,2,3,0,1,2,3; no starvation.
- Wait states: hreadyout=0 for 2 cycles in ADDR and 3 in DATA -> haddr/htrans/hwdata stable throughout, ack at cycle 4+5=9.
- Error: hresp=1 with hreadyout=1 in DATA for client 1 -> ack=4'b0010, err=1 for one cycle, next transfer err=0.
- Reset mid-transfer: hresetn=0 during DATA -> next cycle htrans=IDLE, hsel=0, ack=0, pointer=0; after release req[3] alone granted normally.

Source files
------------

// File: rtl/peripheral_ahb4_arbiter.sv
// Round-robin arbiter that serialises single client transfers onto one AHB4 slave.
// Each transfer runs one address phase and one data phase, and it completes with a one-cycle ack.
module peripheral_ahb4_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned HADDR_SIZE  = 8,
    parameter int unsigned HDATA_SIZE  = 32
) (
    input  logic                              hclk,
    input  logic                              hresetn,
    input  logic [NUM_MASTERS-1:0]            req,
    input  logic [NUM_MASTERS*HADDR_SIZE-1:0] req_addr,
    input  logic [NUM_MASTERS-1:0]            req_write,
    input  logic [NUM_MASTERS*3-1:0]          req_size,
    input  logic [NUM_MASTERS*HDATA_SIZE-1:0] req_wdata,
    output logic [NUM_MASTERS-1:0]            ack,
    output logic                              err,
    output logic [HDATA_SIZE-1:0]             rdata,
    output logic                              hsel,
    output logic [HADDR_SIZE-1:0]             haddr,
    output logic [HDATA_SIZE-1:0]             hwdata,
    output logic                              hwrite,
    output logic [2:0]                        hsize,
    output logic [2:0]                        hburst,
    output logic [3:0]                        hprot,
    output logic [1:0]                        htrans,
    output logic                              hmastlock,
    output logic                              hready,
    input  logic                              hreadyout,
    input  logic [HDATA_SIZE-1:0]             hrdata,
    input  logic                              hresp
);

    localparam int unsigned PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           winner_q, winner_d;
    logic [PW-1:0]           grant_idx;
    logic                    grant_found;
    int unsigned             cand;
    logic                    hsel_d, hwrite_d, err_d;
    logic [1:0]              htrans_d;
    logic [HADDR_SIZE-1:0]   haddr_d;
    logic [2:0]              hsize_d;
    logic [HDATA_SIZE-1:0]   hwdata_d, rdata_d;
    logic [NUM_MASTERS-1:0]  ack_d;

    assign hready    = hreadyout;
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign hmastlock = 1'b0;

    // First requester at or above the pointer, wrapping around
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
            cand = (32'(ptr_q) + off) % NUM_MASTERS;
            if (!grant_found && req[PW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        hsel_d   = hsel;
        htrans_d = htrans;
        haddr_d  = haddr;
        hwrite_d = hwrite;
        hsize_d  = hsize;
        hwdata_d = hwdata;
        rdata_d  = rdata;
        ack_d    = '0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hsel_d   = 1'b0;
                htrans_d = HTRANS_IDLE;
                if (grant_found && hreadyout) begin
                    winner_d = grant_idx;
                    haddr_d  = req_addr[32'(grant_idx)*HADDR_SIZE +: HADDR_SIZE];
                    hwrite_d = req_write[grant_idx];
                    hsize_d  = req_size[32'(grant_idx)*3 +: 3];
                    hwdata_d = req_wdata[32'(grant_idx)*HDATA_SIZE +: HDATA_SIZE];
                    hsel_d   = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hreadyout) begin
                    hsel_d   = 1'b0;
                    htrans_d = HTRANS_IDLE;
                    ptr_d    = (32'(winner_q) == NUM_MASTERS - 1) ? '0 : winner_q + PW'(1);
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                // hwdata stays at the latched value until the slave completes
                if (hreadyout) begin
                    if (!hwrite) begin
                        rdata_d = hrdata;
                    end
                    err_d           = hresp;
                    ack_d[winner_q] = 1'b1;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            hsel     <= 1'b0;
            htrans   <= HTRANS_IDLE;
            haddr    <= '0;
            hwrite   <= 1'b0;
            hsize    <= '0;
            hwdata   <= '0;
            rdata    <= '0;
            ack      <= '0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            hsel     <= hsel_d;
            htrans   <= htrans_d;
            haddr    <= haddr_d;
            hwrite   <= hwrite_d;
            hsize    <= hsize_d;
            hwdata   <= hwdata_d;
            rdata    <= rdata_d;
            ack      <= ack_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_peripheral_ahb4_arbiter.sv
// Directed bench: a small SRAM slave, a stimulus process and a scoreboard monitor keyed on ack.
module tb_peripheral_ahb4_arbiter;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic              hclk = 1'b0;
    logic              hresetn;
    logic [NM-1:0]     req;
    logic [NM*AW-1:0]  req_addr;
    logic [NM-1:0]     req_write;
    logic [NM*3-1:0]   req_size;
    logic [NM*DW-1:0]  req_wdata;
    logic [NM-1:0]     ack;
    logic              err;
    logic [DW-1:0]     rdata;
    logic              hsel;
    logic [AW-1:0]     haddr;
    logic [DW-1:0]     hwdata;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic [1:0]        htrans;
    logic              hmastlock;
    logic              hready;
    logic              hreadyout;
    logic [DW-1:0]     hrdata;
    logic              hresp;

    logic [AW-1:0]     c_addr  [NM];
    logic              c_write [NM];
    logic [2:0]        c_size  [NM];
    logic [DW-1:0]     c_wdata [NM];

    logic [DW-1:0]     mem [256];
    logic              dp_active = 1'b0;
    logic              dp_write  = 1'b0;
    logic [AW-1:0]     dp_addr   = '0;

    typedef struct packed {
        logic [NM-1:0] ack;
        logic          err;
        logic          chk_rd;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    logic mon_en  = 1'b0;
    int   e;

    peripheral_ahb4_arbiter #(.NUM_MASTERS(NM), .HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
        .hclk(hclk), .hresetn(hresetn), .req(req), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .ack(ack), .err(err), .rdata(rdata), .hsel(hsel), .haddr(haddr),
        .hwdata(hwdata), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock), .hready(hready),
        .hreadyout(hreadyout), .hrdata(hrdata), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            req_addr[i*AW +: AW]  = c_addr[i];
            req_write[i]          = c_write[i];
            req_size[i*3 +: 3]    = c_size[i];
            req_wdata[i*DW +: DW] = c_wdata[i];
        end
    end

    // SRAM slave: address accepted when hready, write/read resolved in the data phase
    assign hrdata = mem[dp_addr];
    always @(posedge hclk) begin
        if (dp_active && hreadyout && dp_write) mem[dp_addr] <= hwdata;
        if (hready) begin
            dp_active <= hsel && (htrans == 2'b10);
            dp_addr   <= haddr;
            dp_write  <= hwrite;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ack(input int m, input logic e_err, input logic e_chk, input logic [DW-1:0] e_rd);
        exp_t x;
        x.ack    = NM'(1 << m);
        x.err    = e_err;
        x.chk_rd = e_chk;
        x.rdata  = e_rd;
        sb.push_back(x);
    endtask

    // Raise mask, wait for n acks, drop all requests in the n-th ack cycle
    task automatic issue(input logic [NM-1:0] mask, input int n, output int edges);
        int seen;
        seen  = 0;
        edges = 0;
        req   = mask;
        while (seen < n && edges < 200) begin
            @(negedge hclk);
            edges++;
            if (ack != '0) begin
                seen++;
                if (seen == n) req = '0;
            end
        end
        req = '0;
        chk("ack_count", 32'(seen), 32'(n));
    endtask

    // Scoreboard monitor
    always @(negedge hclk) begin
        exp_t x;
        if (mon_en) begin
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    x = sb.pop_front();
                    chk("sb_ack", 32'(ack), 32'(x.ack));
                    chk("sb_err", 32'(err), 32'(x.err));
                    if (x.chk_rd) chk("sb_rdata", rdata, x.rdata);
                end
            end else begin
                chk("err_without_ack", 32'(err), 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hresetn   = 1'b0;
        req       = '0;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'h1122_3344;
        for (int i = 0; i < NM; i++) begin
            mem[8'h40 + i] = 32'hA000_0000 + 32'(i);
            c_addr[i]  = 8'h40 + 8'(i);
            c_write[i] = 1'b0;
            c_size[i]  = 3'd2;
            c_wdata[i] = '0;
        end

        repeat (2) @(negedge hclk);
        mon_en = 1'b1;
        chk("rst_htrans", 32'(htrans), 32'h0);
        chk("rst_hsel", 32'(hsel), 32'h0);
        chk("rst_haddr", 32'(haddr), 32'h0);
        chk("rst_hwrite", 32'(hwrite), 32'h0);
        chk("rst_hsize", 32'(hsize), 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("hburst", 32'(hburst), 32'h0);
        chk("hprot", 32'(hprot), 32'h3);
        chk("hmastlock", 32'(hmastlock), 32'h0);
        hresetn = 1'b1;
        @(negedge hclk);

        // Single read, client 2
        c_addr[2] = 8'h10;
        expect_ack(2, 1'b0, 1'b1, 32'h1122_3344);
        req = 4'b0100;
        @(negedge hclk);
        chk("t1_addr_htrans", 32'(htrans), 32'h2);
        chk("t1_addr_hsel", 32'(hsel), 32'h1);
        chk("t1_addr_haddr", 32'(haddr), 32'h10);
        chk("t1_addr_hsize", 32'(hsize), 32'h2);
        chk("t1_hready", 32'(hready), 32'h1);
        @(negedge hclk);
        chk("t1_data_htrans", 32'(htrans), 32'h0);
        chk("t1_data_hsel", 32'(hsel), 32'h0);
        @(negedge hclk);
        chk("t1_ack_cycle4", 32'(ack), 32'h4);
        req = '0;

        // Write then read, client 0 (rdata holds over the write)
        c_addr[0] = 8'h20; c_write[0] = 1'b1; c_wdata[0] = 32'hDEAD_BEEF;
        expect_ack(0, 1'b0, 1'b1, 32'h1122_3344);
        issue(4'b0001, 1, e);
        chk("t2_wr_latency", 32'(e), 32'd3);
        c_write[0] = 1'b0;
        expect_ack(0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        issue(4'b0001, 1, e);

        // Client 3 alone, pointer wraps to 0
        expect_ack(3, 1'b0, 1'b1, 32'hA000_0003);
        issue(4'b1000, 1, e);

        // Round robin with all requests held
        c_addr[0] = 8'h40;
        c_addr[2] = 8'h42;
        for (int k = 0; k < 8; k++) expect_ack(k % 4, 1'b0, 1'b1, 32'hA000_0000 + 32'(k % 4));
        issue(4'b1111, 8, e);
        chk("rr_throughput", 32'(e), 32'd24);

        // Wait states: 2 in address phase, 3 in data phase
        c_addr[1] = 8'h30; c_write[1] = 1'b1; c_wdata[1] = 32'h55AA_55AA;
        expect_ack(1, 1'b0, 1'b1, 32'hA000_0003);
        req = 4'b0010;
        @(negedge hclk);
        hreadyout = 1'b0;
        repeat (2) begin
            @(negedge hclk);
            chk("ws_addr_haddr", 32'(haddr), 32'h30);
            chk("ws_addr_htrans", 32'(htrans), 32'h2);
            chk("ws_addr_hwdata", hwdata, 32'h55AA_55AA);
            chk("ws_hready", 32'(hready), 32'h0);
        end
        hreadyout = 1'b1;
        @(negedge hclk);
        hreadyout = 1'b0;
        repeat (3) begin
            @(negedge hclk);
            chk("ws_data_htrans", 32'(htrans), 32'h0);
            chk("ws_data_hwdata", hwdata, 32'h55AA_55AA);
            chk("ws_data_noack", 32'(ack), 32'h0);
        end
        hreadyout = 1'b1;
        @(negedge hclk);
        chk("ws_ack_cycle9", 32'(ack), 32'h2);
        req = '0;

        // ERROR response on client 1, then a clean transfer
        c_write[1] = 1'b0;
        expect_ack(1, 1'b1, 1'b1, 32'h55AA_55AA);
        req = 4'b0010;
        @(negedge hclk);
        @(negedge hclk);
        hresp = 1'b1;
        @(negedge hclk);
        chk("err_ack", 32'(ack), 32'h2);
        chk("err_flag", 32'(err), 32'h1);
        hresp = 1'b0;
        req   = '0;
        c_addr[2] = 8'h10;
        expect_ack(2, 1'b0, 1'b1, 32'h1122_3344);
        issue(4'b0100, 1, e);

        // Reset during a stalled data phase
        req = 4'b0010;
        @(negedge hclk);
        @(negedge hclk);
        hreadyout = 1'b0;
        hresetn   = 1'b0;
        req       = '0;
        @(negedge hclk);
        chk("mrst_htrans", 32'(htrans), 32'h0);
        chk("mrst_hsel", 32'(hsel), 32'h0);
        chk("mrst_ack", 32'(ack), 32'h0);
        chk("mrst_rdata", rdata, 32'h0);
        hresetn   = 1'b1;
        hreadyout = 1'b1;
        expect_ack(1, 1'b0, 1'b1, 32'h55AA_55AA);
        issue(4'b1010, 1, e);
        c_addr[3] = 8'h43;
        expect_ack(3, 1'b0, 1'b1, 32'hA000_0003);
        issue(4'b1000, 1, e);
        chk("post_rst_latency", 32'(e), 32'd3);

        repeat (3) @(negedge hclk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
